// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side byte-serial load/store initiator for a big-endian byte memory.
// Latency: accept at edge E -> rsp_valid in the cycle after edge E+N (N = 1/2/4 bytes); errors respond one cycle after accept.
// Backpressure: req_ready is high only in IDLE; one request in flight, req_* ignored while busy.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   req_*                request handshake (valid/ready), fields latched on acceptance
//   rsp_*                one-cycle completion pulse with error flag and extended load data
//   mem_*                byte port: registered address/data/active-low strobes, combinational read data

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we_n,
    output logic              mem_rd_n,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request and access bookkeeping
    logic              write_q,  write_d;
    logic              signed_q, signed_d;
    logic [1:0]        size_q,   size_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic              err_q,    err_d;
    logic [1:0]        idx_q,    idx_d;
    logic [31:0]       acc_q,    acc_d;
    logic [31:0]       rdata_q,  rdata_d;

    // Registered memory-side outputs
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_n_q,  mem_we_n_d;
    logic              mem_rd_n_q,  mem_rd_n_d;

    logic              req_err;
    logic              last_beat;

    // Index of the final byte for a size code (byte, half, word)
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    // Byte i counted MSB-first within the low (last+1) bytes of the store data
    function automatic logic [7:0] wr_byte(input logic [31:0] data,
                                           input logic [1:0]  last,
                                           input logic [1:0]  i);
        logic [1:0] sel;
        sel     = last - i;
        wr_byte = data[{sel, 3'b000} +: 8];
    endfunction

    // Sign/zero extension of the low 8N bits of the assembled load data
    function automatic logic [31:0] extend(input logic [31:0] acc,
                                           input logic [1:0]  size,
                                           input logic        sgn);
        case (size)
            2'b00:   extend = {{24{sgn & acc[7]}},  acc[7:0]};
            2'b01:   extend = {{16{sgn & acc[15]}}, acc[15:0]};
            default: extend = acc;
        endcase
    endfunction

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

    assign last_beat = (idx_q == last_idx(size_q));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? DONE : ACCESS;
            ACCESS:  if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_n_d  = 1'b1;
        mem_rd_n_d  = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    size_d   = req_size;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    idx_d    = 2'd0;
                    acc_d    = 32'd0;
                    if (req_err) begin
                        // No memory cycle; response data is cleared as DONE is entered
                        rdata_d = 32'd0;
                    end else begin
                        // Strobes for byte 0 are set up here so they are valid
                        // for the whole first ACCESS cycle
                        mem_addr_d  = req_addr;
                        mem_wdata_d = wr_byte(req_wdata, last_idx(req_size), 2'd0);
                        mem_we_n_d  = ~req_write;
                        mem_rd_n_d  = req_write;
                    end
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    acc_d = {acc_q[23:0], mem_rdata};
                end
                if (last_beat) begin
                    rdata_d = write_q ? 32'd0 : extend(acc_d, size_q, signed_q);
                end else begin
                    idx_d       = idx_q + 2'd1;
                    mem_addr_d  = addr_q + {{(ADDR_W-2){1'b0}}, idx_d};
                    mem_wdata_d = wr_byte(wdata_q, last_idx(size_q), idx_d);
                    mem_we_n_d  = ~write_q;
                    mem_rd_n_d  = write_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            idx_q       <= 2'd0;
            acc_q       <= 32'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_n_q  <= 1'b1;
            mem_rd_n_q  <= 1'b1;
        end else begin
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_n_q  <= mem_we_n_d;
            mem_rd_n_q  <= mem_rd_n_d;
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
        rsp_err   = (state_q == DONE) & err_q;
        rsp_rdata = rdata_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_we_n  = mem_we_n_q;
        mem_rd_n  = mem_rd_n_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we_n;
    logic        mem_rd_n;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [32:0] mon_q[$];
    logic [32:0] exp_q[$];

    load_store_unit #(.ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we_n   (mem_we_n),
        .mem_rd_n   (mem_rd_n),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    // Byte memory: combinational read, write committed on falling edge
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(negedge clock) begin
        if (!mem_we_n) mem[mem_addr[7:0]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Record every active memory cycle as {is_write, address}
    always @(negedge clock) begin
        if (reset && (!mem_we_n || !mem_rd_n)) begin
            mon_q.push_back({~mem_we_n, mem_addr});
            check("strobe_excl", {31'd0, mem_we_n | mem_rd_n}, 32'd1);
        end
    end

    task automatic set_byte(input int a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Reference model: whole-transaction view of the request
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int n);
        longint v;
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        rd = 32'd0;
        v  = 0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({w, a + 32'(i)});
                if (w) ref_mem[8'(a + 32'(i))] = 8'(wd >> (8 * (n - 1 - i)));
                else   v = v * 256 + longint'(ref_mem[8'(a + 32'(i))]);
            end
            if (!w) begin
                if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                rd = 32'(v);
            end
        end
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!req_ready && t < 20);
        check("ready_wait", {31'd0, req_ready}, 32'd1);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic scramble_req();
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_err,
                            input logic [31:0] exp_rd);
        int lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_nacc"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
            check({tag, "_acc"}, mon_q[i][31:0] ^ {31'd0, mon_q[i][32]} ^ 32'(i << 8),
                  exp_q[i][31:0] ^ {31'd0, exp_q[i][32]} ^ 32'(i << 8));
        mon_q.delete();
        exp_q.delete();
        @(negedge clock);
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_hold"}, rsp_rdata, exp_rd);
    endtask

    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] rd;
        int          n;
        model(w, sz, sg, a, wd, e, rd, n);
        send(w, sz, sg, a, wd);
        req_valid = 1'b0;
        scramble_req();
        wait_rsp(tag, e ? 1 : n + 1, e, rd);
        if (w && !e)
            for (int i = 0; i < n; i++)
                check({tag, "_stmem"}, {24'd0, mem[8'(a + 32'(i))]}, {24'd0, ref_mem[8'(a + 32'(i))]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e1, e2;
        logic [31:0] rd1, rd2;
        int          n1, n2;
        int          diff;

        for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom));

        // Reset state
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_vld", {31'd0, rsp_valid}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_we", {31'd0, mem_we_n}, 32'd1);
        check("rst_rd", {31'd0, mem_rd_n}, 32'd1);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        #10 reset = 1'b1;

        // Word load from addresses 8..11
        set_byte(8, 8'h00); set_byte(9, 8'h00); set_byte(10, 8'h00); set_byte(11, 8'h05);
        txn("ldw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'd0);

        // Signed/unsigned byte loads of 0x80
        set_byte(20, 8'h80);
        txn("ldbs", 1'b0, 2'b00, 1'b1, 32'd20, 32'd0);
        txn("ldbu", 1'b0, 2'b00, 1'b0, 32'd20, 32'd0);

        // Halfword store then reload
        txn("sth", 1'b1, 2'b01, 1'b0, 32'd12, 32'h1234ABCD);
        txn("ldh", 1'b0, 2'b01, 1'b0, 32'd12, 32'd0);
        txn("ldhs", 1'b0, 2'b01, 1'b1, 32'd12, 32'd0);

        // Errors: misaligned word, illegal size, misaligned half store
        txn("misw", 1'b0, 2'b10, 1'b0, 32'd6, 32'd0);
        txn("ill", 1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
        txn("mish", 1'b1, 2'b01, 1'b0, 32'd13, 32'hFFFF);

        // Reset in the second cycle of a word store
        set_byte(18, 8'h11); set_byte(19, 8'h22);
        send(1'b1, 2'b10, 1'b0, 32'd16, 32'hDEADBEEF);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_we", {31'd0, mem_we_n}, 32'd1);
        check("arst_rd", {31'd0, mem_rd_n}, 32'd1);
        check("arst_vld", {31'd0, rsp_valid}, 32'd0);
        ref_mem[16] = 8'hDE;
        ref_mem[17] = 8'hAD;
        mon_q.delete();
        for (int a = 16; a < 20; a++)
            check("arst_mem", {24'd0, mem[a]}, {24'd0, ref_mem[a]});
        @(negedge clock);
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("arst_novld", {31'd0, rsp_valid}, 32'd0);
            check("arst_ready", {31'd0, req_ready}, 32'd1);
        end

        // Two queued loads with req_valid held high
        model(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, e1, rd1, n1);
        send(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
        req_size   = 2'b00;
        req_signed = 1'b1;
        req_addr   = 32'd20;
        wait_rsp("q1", n1 + 1, e1, rd1);
        model(1'b0, 2'b00, 1'b1, 32'd20, 32'd0, e2, rd2, n2);
        @(posedge clock);
        #1 req_valid = 1'b0;
        scramble_req();
        wait_rsp("q2", n2 + 1, e2, rd2);

        // Randomised mix
        for (int k = 0; k < 150; k++) begin
            logic        w, sg;
            logic [1:0]  sz;
            logic [31:0] a;
            w  = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            txn("rnd", w, sz, sg, a, $urandom);
        end

        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("final_mem", 32'(diff), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
